mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline. It sits between the ex_mem pipeline register and the mem_wb register. It passes ALU results straight through and runs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) as byte-serial transfers over the memory-controller port. While an access is in flight it raises a stall request so the upstream stages and ex_mem hold; when the access completes it presents the write-back triple to mem_wb.

---
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Byte-serial memory-controller port used by the pipeline memory stage.
// The stage is the master: it issues one byte transfer at a time and the
// controller reports completion with mc_done.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            mc_req;
    logic            mc_we;
    logic [XLEN-1:0] mc_addr;
    logic [7:0]      mc_wdata;
    logic [7:0]      mc_rdata;
    logic            mc_done;

    modport master (
        output mc_req,
        output mc_we,
        output mc_addr,
        output mc_wdata,
        input  mc_rdata,
        input  mc_done
    );

    modport slave (
        input  mc_req,
        input  mc_we,
        input  mc_addr,
        input  mc_wdata,
        output mc_rdata,
        output mc_done
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage RV32I pipeline.
// ALU results pass straight through with zero latency. Loads and stores run
// as byte-serial transfers (little-endian) over the memory-controller port
// while the stage holds the upstream pipeline with stallreq_mem. The
// write-back triple is presented for exactly one cycle when an access ends.
module mem_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [XLEN-1:0]       ex_wdata,
    input  logic                  mem_ld,
    input  logic                  mem_st,
    input  logic [2:0]            mem_funct3,
    input  logic [XLEN-1:0]       mem_addr,
    input  logic [XLEN-1:0]       mem_sdata,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [XLEN-1:0]       mem_wdata,
    output logic                  stallreq_mem,
    mem_stage_if.master           mc
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [1:0]      cnt_r, cnt_s;
    logic [XLEN-1:0] lbuf_r, lbuf_s;
    logic            mem_op_s;
    logic [1:0]      last_cnt_s;
    logic [XLEN-1:0] sdata_shift_s;

    // Index of the final byte of an access; the reserved size 11 acts as a word.
    function automatic logic [1:0] last_byte(input logic [1:0] size);
        logic [1:0] res;
        case (size)
            2'b00:   res = 2'd0;
            2'b01:   res = 2'd1;
            default: res = 2'd3;
        endcase
        return res;
    endfunction

    // Sign- or zero-extend the assembled load bytes to XLEN.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [2:0]      f3);
        logic [XLEN-1:0] res;
        case (f3[1:0])
            2'b00:   res = f3[2] ? {{(XLEN-8){1'b0}}, raw[7:0]}
                             : {{(XLEN-8){raw[7]}}, raw[7:0]};
            2'b01:   res = f3[2] ? {{(XLEN-16){1'b0}}, raw[15:0]}
                             : {{(XLEN-16){raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign mem_op_s      = mem_ld | mem_st;
    assign last_cnt_s    = last_byte(mem_funct3[1:0]);
    assign sdata_shift_s = mem_sdata >> {cnt_r, 3'b000};

    // State, byte counter and load buffer registers; reset clears them at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            lbuf_r  <= {XLEN{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            lbuf_r  <= lbuf_s;
        end
    end

    // Next-state, datapath update and all outputs; every output is forced to zero during reset.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        lbuf_s       = lbuf_r;
        mem_wd       = {REG_ADDR_W{1'b0}};
        mem_wreg     = 1'b0;
        mem_wdata    = {XLEN{1'b0}};
        stallreq_mem = 1'b0;
        mc.mc_req    = 1'b0;
        mc.mc_we     = 1'b0;
        mc.mc_addr   = {XLEN{1'b0}};
        mc.mc_wdata  = 8'd0;
        if (rst) begin
            case (state_r)
                ST_IDLE: begin
                    mem_wd = ex_wd;
                    if (mem_op_s) begin
                        stallreq_mem = 1'b1;
                        cnt_s        = 2'd0;
                        lbuf_s       = {XLEN{1'b0}};
                        state_s      = ST_ACCESS;
                    end else begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = ex_wdata;
                    end
                end
                ST_ACCESS: begin
                    mem_wd       = ex_wd;
                    stallreq_mem = 1'b1;
                    mc.mc_req    = 1'b1;
                    mc.mc_we     = mem_st & ~mem_ld;
                    mc.mc_addr   = mem_addr + {{(XLEN-2){1'b0}}, cnt_r};
                    mc.mc_wdata  = sdata_shift_s[7:0];
                    if (mc.mc_done) begin
                        if (mem_ld) begin
                            case (cnt_r)
                                2'd0:    lbuf_s[7:0]   = mc.mc_rdata;
                                2'd1:    lbuf_s[15:8]  = mc.mc_rdata;
                                2'd2:    lbuf_s[23:16] = mc.mc_rdata;
                                default: lbuf_s[31:24] = mc.mc_rdata;
                            endcase
                        end else begin
                            lbuf_s = lbuf_r;
                        end
                        if (cnt_r == last_cnt_s) begin
                            state_s = ST_DONE;
                        end else begin
                            cnt_s = cnt_r + 2'd1;
                        end
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end
                ST_DONE: begin
                    mem_wd  = ex_wd;
                    state_s = ST_IDLE;
                    if (mem_ld) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = extend_load(lbuf_r, mem_funct3);
                    end else begin
                        mem_wreg  = 1'b0;
                        mem_wdata = {XLEN{1'b0}};
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage. A byte-addressed memory image
// and the architectural load/store rules provide every expected value.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        mem_ld;
    logic        mem_st;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq_mem;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [logic [31:0]];

    mem_stage_if #(.XLEN(32)) mc_if ();

    mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .mem_ld       (mem_ld),
        .mem_st       (mem_st),
        .mem_funct3   (mem_funct3),
        .mem_addr     (mem_addr),
        .mem_sdata    (mem_sdata),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .stallreq_mem (stallreq_mem),
        .mc           (mc_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        else return a[7:0] ^ 8'h5A;
    endfunction

    // One pass-through cycle; optionally pulses mc_done to show it is ignored.
    task automatic alu_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic pulse_done);
        @(negedge clk);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        mem_ld = 1'b0; mem_st = 1'b0;
        mem_funct3 = 3'($urandom); mem_addr = $urandom; mem_sdata = $urandom;
        mc_if.mc_done = pulse_done; mc_if.mc_rdata = 8'($urandom);
        #1;
        check("alu_wd", 32'(mem_wd), 32'(wd));
        check("alu_wreg", 32'(mem_wreg), 32'(wreg));
        check("alu_wdata", mem_wdata, wdata);
        check("alu_stall", 32'(stallreq_mem), 32'd0);
        check("alu_req", 32'(mc_if.mc_req), 32'd0);
    endtask

    // A full load or store; wait_fixed < 0 picks a random wait per byte.
    task automatic mem_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input int wait_fixed, output logic [31:0] got);
        int          n;
        int          w;
        logic [31:0] exp;
        logic [31:0] a;
        logic [7:0]  b;
        logic [4:0]  wd;
        logic        wreg;
        logic        is_wr;
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        wd    = 5'($urandom);
        wreg  = 1'($urandom);
        is_wr = st & ~ld;
        exp   = 32'd0;
        @(negedge clk);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = $urandom;
        mem_ld = ld; mem_st = st; mem_funct3 = f3; mem_addr = addr; mem_sdata = sdata;
        mc_if.mc_done = 1'b0;
        #1;
        check("idle_stall", 32'(stallreq_mem), 32'd1);
        check("idle_req", 32'(mc_if.mc_req), 32'd0);
        check("idle_wreg", 32'(mem_wreg), 32'd0);
        for (int i = 0; i < n; i++) begin
            w = (wait_fixed < 0) ? int'($urandom_range(0, 3)) : wait_fixed;
            a = addr + 32'(i);
            b = 8'(sdata >> (8 * i));
            for (int k = 0; k <= w; k++) begin
                @(negedge clk);
                mc_if.mc_done  = (k == w);
                mc_if.mc_rdata = (k == w) ? mem_rd(a) : 8'($urandom);
                #1;
                check("acc_req", 32'(mc_if.mc_req), 32'd1);
                check("acc_stall", 32'(stallreq_mem), 32'd1);
                check("acc_addr", mc_if.mc_addr, a);
                check("acc_we", 32'(mc_if.mc_we), 32'(is_wr));
                check("acc_wreg", 32'(mem_wreg), 32'd0);
                if (is_wr) check("acc_wdata", 32'(mc_if.mc_wdata), 32'(b));
            end
            if (ld) exp = exp | ({24'd0, mem_rd(a)} << (8 * i));
            else mem[a] = b;
        end
        if (ld && !f3[2] && n == 1 && exp[7])  exp = exp | 32'hFFFF_FF00;
        if (ld && !f3[2] && n == 2 && exp[15]) exp = exp | 32'hFFFF_0000;
        @(negedge clk);
        mc_if.mc_done = 1'($urandom);
        mc_if.mc_rdata = 8'($urandom);
        #1;
        check("done_stall", 32'(stallreq_mem), 32'd0);
        check("done_req", 32'(mc_if.mc_req), 32'd0);
        check("done_wd", 32'(mem_wd), 32'(wd));
        check("done_wreg", 32'(mem_wreg), ld ? 32'(wreg) : 32'd0);
        check("done_wdata", mem_wdata, ld ? exp : 32'd0);
        got = mem_wdata;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wd"}, 32'(mem_wd), 32'd0);
        check({tag, "_wreg"}, 32'(mem_wreg), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_stall"}, 32'(stallreq_mem), 32'd0);
        check({tag, "_req"}, 32'(mc_if.mc_req), 32'd0);
        check({tag, "_we"}, 32'(mc_if.mc_we), 32'd0);
        check({tag, "_addr"}, mc_if.mc_addr, 32'd0);
        check({tag, "_mcwdata"}, 32'(mc_if.mc_wdata), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        int          sel;
        logic [31:0] addr;

        // Reset held with live inputs: outputs must all be zero.
        rst = 1'b0;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
        mem_ld = 1'b1; mem_st = 1'b0; mem_funct3 = 3'b010;
        mem_addr = 32'h0000_0040; mem_sdata = 32'h1111_2222;
        mc_if.mc_done = 1'b0; mc_if.mc_rdata = 8'd0;
        #2;
        check_all_zero("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1; mem_ld = 1'b0;

        // Directed cases.
        alu_op(5'd5, 1'b1, 32'h0000_1234, 1'b0);
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56;
        mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        mem_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, got);
        check("lw_value", got, 32'h1234_5678);
        mem[32'h200] = 8'h80; mem[32'h201] = 8'hFF;
        mem_op(1'b1, 1'b0, 3'b000, 32'h200, 32'd0, -1, got);
        check("lb_value", got, 32'hFFFF_FF80);
        mem_op(1'b1, 1'b0, 3'b100, 32'h200, 32'd0, -1, got);
        check("lbu_value", got, 32'h0000_0080);
        mem_op(1'b1, 1'b0, 3'b001, 32'h200, 32'd0, -1, got);
        check("lh_value", got, 32'hFFFF_FF80);
        mem_op(1'b1, 1'b0, 3'b101, 32'h200, 32'd0, -1, got);
        check("lhu_value", got, 32'h0000_FF80);
        mem_op(1'b0, 1'b1, 3'b001, 32'h3, 32'hAABB_CCDD, 2, got);
        mem_op(1'b1, 1'b0, 3'b001, 32'h3, 32'd0, 1, got);
        check("sh_readback", got, 32'hFFFF_CCDD);
        mem_op(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 0, got);

        // mc_done while idle with an ALU op is ignored.
        alu_op(5'd9, 1'b1, 32'hCAFE_0001, 1'b1);
        alu_op(5'd10, 1'b0, 32'hCAFE_0002, 1'b1);
        alu_op(5'd11, 1'b1, 32'hCAFE_0003, 1'b0);

        // Reset during the second byte of an LW.
        @(negedge clk);
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h5555_AAAA;
        mem_ld = 1'b1; mem_st = 1'b0; mem_funct3 = 3'b010; mem_addr = 32'h100;
        mc_if.mc_done = 1'b0;
        @(negedge clk);
        mc_if.mc_done = 1'b1; mc_if.mc_rdata = 8'h78;
        @(negedge clk);
        mc_if.mc_done = 1'b0;
        #1;
        check("rstmid_addr", mc_if.mc_addr, 32'h101);
        rst = 1'b0;
        #1;
        check_all_zero("rstmid");
        @(negedge clk);
        rst = 1'b1; mem_ld = 1'b0;
        alu_op(5'd12, 1'b1, 32'h0BAD_F00D, 1'b0);

        // Randomized mix against the memory model.
        for (int t = 0; t < 80; t++) begin
            sel  = int'($urandom_range(0, 3));
            addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                               : 32'($urandom_range(0, 63));
            case (sel)
                0:       alu_op(5'($urandom), 1'($urandom), $urandom, 1'($urandom));
                1:       mem_op(1'b1, 1'b0, 3'($urandom), addr, $urandom, -1, got);
                2:       mem_op(1'b0, 1'b1, 3'($urandom), addr, $urandom, -1, got);
                default: mem_op(1'b1, 1'b1, 3'($urandom), addr, $urandom, -1, got);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
